// File: rtl/reg_file_sb.sv
// Register file with two write ports (A: ALU, B: load return), two combinational read ports,
// and a per-register load-pending scoreboard with a registered busy count.
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int RST_MODE = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0] rd_data_1,
  output logic              rd_busy_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_busy_2,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_dest,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_dest,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy, wr_a, wr_b, set_vec, clr_vec;
  logic                            inc, dec;

  function automatic logic [DATA_W-1:0] rst_val(input int i);
    return (RST_MODE == 1 && !(ZERO_REG != 0 && i == 0)) ? DATA_W'(i) : '0;
  endfunction

  // One-hot decode of every write/issue/clear; register 0 is masked out when hardwired.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_dec
    localparam bit LIVE = !(ZERO_REG != 0 && i == 0);
    assign wr_a[i]    = LIVE && wa_en  && wa_dest  == ADDR_W'(i);
    assign wr_b[i]    = LIVE && wb_en  && wb_dest  == ADDR_W'(i);
    assign set_vec[i] = LIVE && iss_en && iss_dest == ADDR_W'(i);
    assign clr_vec[i] = wb_en && wb_dest == ADDR_W'(i);
  end

  // Count moves only on real busy transitions; a set+clear on one reg nets to "stay busy".
  assign inc = |(set_vec & ~busy);
  assign dec = |(clr_vec & busy & ~set_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= rst_val(i);
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_b[i])      regs[i] <= wb_data;
        else if (wr_a[i]) regs[i] <= wa_data;
      end
      busy     <= set_vec | (busy & ~clr_vec);
      busy_cnt <= busy_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
    end
  end

  logic [1:0][ADDR_W-1:0] ra;
  logic [1:0][DATA_W-1:0] rdat;
  logic [1:0]             rbsy;

  assign ra = {rd_addr_2, rd_addr_1};

  always_comb begin
    rdat = '0;
    rbsy = '0;
    for (int p = 0; p < 2; p++) begin
      rdat[p] = regs[ra[p]];
      rbsy[p] = busy[ra[p]];
      if (BYPASS != 0) begin
        if (wr_a[ra[p]]) rdat[p] = wa_data;
        if (wr_b[ra[p]]) rdat[p] = wb_data;
        if (clr_vec[ra[p]] && !set_vec[ra[p]]) rbsy[p] = 1'b0;
      end
      if (ZERO_REG != 0 && ra[p] == '0) begin
        rdat[p] = '0;
        rbsy[p] = 1'b0;
      end
    end
  end

  assign rd_data_1 = rdat[0];
  assign rd_busy_1 = rbsy[0];
  assign rd_data_2 = rdat[1];
  assign rd_busy_2 = rbsy[1];
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a bypassing instance with index reset values and a non-bypassing
// instance with zero reset values share stimulus and are checked against an array model.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  ra1, ra2, wad, wbd, isd;
  logic        wae, wbe, ise;
  logic [15:0] wadat, wbdat;

  logic [1:0][15:0] d1, d2;
  logic [1:0]       b1, b2;
  logic [1:0][3:0]  cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [2][8];
  bit          m_busy [8];
  bit          byp    [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  reg_file_sb u0 (
    .clk(clk), .rst(rst),
    .rd_addr_1(ra1), .rd_data_1(d1[0]), .rd_busy_1(b1[0]),
    .rd_addr_2(ra2), .rd_data_2(d2[0]), .rd_busy_2(b2[0]),
    .wa_en(wae), .wa_dest(wad), .wa_data(wadat),
    .wb_en(wbe), .wb_dest(wbd), .wb_data(wbdat),
    .iss_en(ise), .iss_dest(isd), .busy_cnt(cnt[0])
  );

  reg_file_sb #(.RST_MODE(0), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst),
    .rd_addr_1(ra1), .rd_data_1(d1[1]), .rd_busy_1(b1[1]),
    .rd_addr_2(ra2), .rd_data_2(d2[1]), .rd_busy_2(b2[1]),
    .wa_en(wae), .wa_dest(wad), .wa_data(wadat),
    .wb_en(wbe), .wb_dest(wbd), .wb_data(wbdat),
    .iss_en(ise), .iss_dest(isd), .busy_cnt(cnt[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input int k, input logic [2:0] a);
    if (a == 3'd0) return 16'h0;
    if (byp[k] && wbe && wbd == a) return wbdat;
    if (byp[k] && wae && wad == a) return wadat;
    return m_regs[k][a];
  endfunction

  function automatic logic exp_busy(input int k, input logic [2:0] a);
    if (a == 3'd0) return 1'b0;
    if (byp[k] && wbe && wbd == a && !(ise && isd == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int pop_busy();
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[0][i] = 16'(i);
      m_regs[1][i] = 16'h0;
      m_busy[i]    = 1'b0;
    end
  endtask

  // Writes applied A then B so B wins; clear applied before issue so issue wins.
  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      if (wae && wad != 3'd0) m_regs[k][wad] = wadat;
      if (wbe && wbd != 3'd0) m_regs[k][wbd] = wbdat;
    end
    if (wbe) m_busy[wbd] = 1'b0;
    if (ise && isd != 3'd0) m_busy[isd] = 1'b1;
  endtask

  task automatic check_all(input string where);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s u%0d rd_data_1", where, k), 32'(d1[k]), 32'(exp_data(k, ra1)));
      chk($sformatf("%s u%0d rd_data_2", where, k), 32'(d2[k]), 32'(exp_data(k, ra2)));
      chk($sformatf("%s u%0d rd_busy_1", where, k), 32'(b1[k]), 32'(exp_busy(k, ra1)));
      chk($sformatf("%s u%0d rd_busy_2", where, k), 32'(b2[k]), 32'(exp_busy(k, ra2)));
      chk($sformatf("%s u%0d busy_cnt", where, k), 32'(cnt[k]), 32'(pop_busy()));
    end
  endtask

  task automatic idle();
    wae = 1'b0; wbe = 1'b0; ise = 1'b0;
  endtask

  task automatic step(input string where);
    #1 check_all(where);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  // Reset raised between edges while writes/issues are pending; those must be discarded.
  task automatic do_reset(input string where);
    idle();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all(where);
    wae = 1'b1; wad = 3'd5; wadat = 16'h1234;
    wbe = 1'b1; wbd = 3'd6; wbdat = 16'h5678;
    ise = 1'b1; isd = 3'd3;
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    ra1 = 3'd5; ra2 = 3'd0; wad = 3'd0; wbd = 3'd0; isd = 3'd0;
    wadat = 16'h0; wbdat = 16'h0;

    // power-on reset asserted mid-cycle
    #3 rst = 1'b1;
    #1 model_reset();
    check_all("reset");
    chk("reset u0 reg5", 32'(d1[0]), 32'h5);
    chk("reset u1 reg5", 32'(d1[1]), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // port A write with same-cycle visibility depending on bypass
    ra1 = 3'd3; wae = 1'b1; wad = 3'd3; wadat = 16'hABCD;
    #1 chk("bypass u0 reg3", 32'(d1[0]), 32'hABCD);
    chk("nobypass u1 reg3", 32'(d1[1]), 32'h0);
    step("wa3");
    idle();
    step("wa3 next");
    chk("wa3 latched u1", 32'(d1[1]), 32'hABCD);

    // same-dest A/B collision and register 0 writes
    ra2 = 3'd4;
    wae = 1'b1; wad = 3'd4; wadat = 16'h1111;
    wbe = 1'b1; wbd = 3'd4; wbdat = 16'h2222;
    step("ab collide");
    idle();
    step("ab after");
    chk("b wins reg4", 32'(d2[1]), 32'h2222);
    ra1 = 3'd0; wae = 1'b1; wad = 3'd0; wadat = 16'hFFFF;
    step("wa0");
    idle();
    step("wa0 after");

    // load issue then return
    ra2 = 3'd6; ise = 1'b1; isd = 3'd6;
    step("iss6");
    idle();
    step("iss6 busy");
    chk("iss6 cnt", 32'(cnt[0]), 32'd1);
    wbe = 1'b1; wbd = 3'd6; wbdat = 16'h0042;
    #1 chk("wb6 busy fwd", 32'(b2[0]), 32'd0);
    chk("wb6 data fwd", 32'(d2[0]), 32'h0042);
    step("wb6");
    idle();
    step("wb6 after");

    // issue and clear on one busy register
    ra1 = 3'd2; ise = 1'b1; isd = 3'd2;
    step("iss2");
    ise = 1'b1; isd = 3'd2; wbe = 1'b1; wbd = 3'd2; wbdat = 16'h0777;
    step("iss2 wb2");
    idle();
    step("iss2 wb2 after");
    chk("set wins busy", 32'(b1[0]), 32'd1);

    // fill scoreboard, re-issue, issue to reg 0
    for (int r = 1; r < 8; r++) begin
      ise = 1'b1; isd = 3'(r); ra2 = 3'(r);
      step($sformatf("fill%0d", r));
    end
    isd = 3'd1; step("reissue1");
    isd = 3'd0; ra1 = 3'd0; step("iss0");
    idle();
    step("full");
    chk("full cnt", 32'(cnt[0]), 32'd7);

    do_reset("mid reset");
    step("post reset");
    chk("post reset cnt", 32'(cnt[0]), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      ra1 = 3'($urandom_range(7)); ra2 = 3'($urandom_range(7));
      wae = 1'($urandom_range(1)); wad = 3'($urandom_range(7)); wadat = 16'($urandom);
      wbe = 1'($urandom_range(1)); wbd = 3'($urandom_range(7)); wbdat = 16'($urandom);
      ise = ($urandom_range(2) != 0); isd = 3'($urandom_range(7));
      if (n % 8 == 7) begin wbd = isd; wbe = 1'b1; end
      step("rand");
      if ($urandom_range(59) == 0) do_reset("rand reset");
    end
    idle();
    step("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised multi-write-port register file with load-use scoreboard and optional write-to-read bypass. It is the next-generation register file for the pipelined core. Port A takes ALU results; port B takes load/memory results. A per-register busy scoreboard marks registers awaiting load data so the hazard unit can stall on reads of pending registers.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, address width; NUM_REGS = 2**ADDR_W
ZERO_REG, 1, 1: register 0 reads 0, ignores writes and issues
RST_MODE, 1, reset contents: 0 = all zero; 1 = register i holds i (truncated to DATA_W)
BYPASS, 1, 1: same-cycle write data and busy-clear are forwarded to read ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
rd_addr_1  in  ADDR_W  read port 1 address
rd_data_1  out  DATA_W  read port 1 data
rd_busy_1  out  1  read port 1 register pending load
rd_addr_2  in  ADDR_W  read port 2 address
rd_data_2  out  DATA_W  read port 2 data
rd_busy_2  out  1  read port 2 register pending load
wa_en  in  1  write port A enable (ALU)
wa_dest  in  ADDR_W  write port A destination
wa_data  in  DATA_W  write port A data
wb_en  in  1  write port B enable (load return)
wb_dest  in  ADDR_W  write port B destination
wb_data  in  DATA_W  write port B data
iss_en  in  1  load issue: mark iss_dest busy
iss_dest  in  ADDR_W  load destination register
busy_cnt  out  ADDR_W+1  number of busy registers (registered)

Behaviour:
- Reset (async, immediate):
  - Contents per RST_MODE; register 0 is 0 when ZERO_REG=1.
  - All busy bits 0; busy_cnt = 0.
  - rd_data_* reflect the reset contents combinationally; rd_busy_* = 0.
  - A reset mid-operation discards pending writes and issues in the same cycle.
- Writes at rising clk edge:
  - wa_en writes wa_data to wa_dest; wb_en writes wb_data to wb_dest.
  - Both enabled to the same dest: port B wins.
  - Writes to register 0 are dropped when ZERO_REG=1.
- Reads are combinational from addresses.
  - BYPASS=0: a written value is visible the cycle after the edge (1-cycle latency).
  - BYPASS=1: if rd_addr matches an active write this cycle, output that write's data (B over A). Register 0 with ZERO_REG=1 always reads 0.
- Scoreboard (one busy bit per register, updated at clk edge):
  - iss_en sets busy[iss_dest].
  - wb_en clears busy[wb_dest]. Port A never clears busy.
  - Set and clear to the same reg in the same cycle: set wins (new load outstanding).
  - Issue to an already-busy reg: stays busy, no count change.
  - Clear of a non-busy reg: no effect.
  - Issue to reg 0 with ZERO_REG=1: ignored.
- rd_busy_n:
  - Equals busy[rd_addr_n].
  - BYPASS=1: forced 0 when wb_en && wb_dest == rd_addr_n this cycle, unless iss_en && iss_dest == rd_addr_n.
  - Always 0 for reg 0 with ZERO_REG=1.
- busy_cnt:
  - Registered; next = current + (effective set of a non-busy reg) − (effective clear of a busy reg).
  - Range 0..NUM_REGS, never wraps.
  - Must always equal the popcount of the busy bits.
- No X on any output after reset regardless of inputs.

Test Plan:
1. Assert rst mid-cycle with defaults → immediately rd_addr_1 = 5 gives rd_data_1 = 16'd5, busy_cnt = 0; with RST_MODE=0 → 16'd0.
2. wa_en, dest 3, data 16'hABCD; BYPASS=1 → rd_data_1 (addr 3) = 16'hABCD in the same cycle; BYPASS=0 → 16'h0003 the same cycle and 16'hABCD the next cycle.
3. wa_en and wb_en both to dest 4, data 16'h1111 / 16'h2222 → reg 4 = 16'h2222; wa_en to dest 0, data 16'hFFFF → rd_data for reg 0 stays 0.
4. iss_en dest 6 → next cycle rd_busy_2 (addr 6) = 1, busy_cnt = 1. Then wb_en dest 6, data 16'h0042 → same cycle rd_busy_2 = 0 and rd_data_2 = 16'h0042 (BYPASS=1); next cycle busy_cnt = 0.
5. Same cycle iss_en dest 2 and wb_en dest 2 with reg 2 busy → reg 2 stays busy, busy_cnt unchanged. Issue regs 1..7 sequentially, then issue 1 again → busy_cnt saturates at 7 with no wrap; iss_dest 0 → ignored.
6. Load 3 pending registers, assert rst → all busy bits 0, busy_cnt = 0, contents back to reset values before the next edge.
